// File: rtl/idli_pkg.sv
// Shared types for the idli core: sync FSM states, the slice-phase counter type
// and the sync debug record carried by the top-level debug bundle.
package idli_pkg;

  localparam int SYNC_SLICE_W = 4;
  localparam int SYNC_DATA_W  = 16;
  localparam int SYNC_CTR_W   = $clog2(SYNC_DATA_W / SYNC_SLICE_W);
  localparam int SYNC_WORD_W  = 16;

  typedef logic [SYNC_CTR_W-1:0] ctr_t;

  typedef enum logic [1:0] {
    SYNC_INIT = 2'd0,
    SYNC_RUN  = 2'd1,
    SYNC_HALT = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic                   run;
    logic [SYNC_WORD_W-1:0] word;
  } debug_sync_t;

endpackage

// File: rtl/idli_sync_m.sv
// Slice-phase counter and pipeline control: post-reset settle delay, halts taken
// only at word boundaries, start/end-of-word strobes and a completed-word count.
module idli_sync_m
  import idli_pkg::*;
#(
  parameter int SLICE_W  = SYNC_SLICE_W,
  parameter int DATA_W   = SYNC_DATA_W,
  parameter int CTR_W    = $clog2(DATA_W / SLICE_W),
  parameter int INIT_CYC = 8,
  parameter int N_CH     = 2,
  parameter int WORD_W   = SYNC_WORD_W
) (
  input  logic              i_sync_gck,
  input  logic              i_sync_rst,
  input  logic [N_CH-1:0]   i_sync_halt_req,
  output logic [N_CH-1:0]   o_sync_halt_ack,
  output logic [CTR_W-1:0]  o_sync_ctr,
  output logic              o_sync_run,
  output logic              o_sync_sow,
  output logic              o_sync_eow,
  output logic [WORD_W-1:0] o_sync_word
);

  localparam int RATIO   = DATA_W / SLICE_W;
  localparam int INIT_CW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  localparam logic [CTR_W-1:0]   CTR_LAST  = CTR_W'(RATIO - 1);
  localparam logic [INIT_CW-1:0] INIT_LAST = INIT_CW'((INIT_CYC > 0) ? INIT_CYC - 1 : 0);

  generate
    if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_ratio
      $error("idli_sync_m: DATA_W/SLICE_W must be a power of two >= 2");
    end
  endgenerate

  sync_state_t        state_reg, state_next;
  logic [INIT_CW-1:0] init_cnt_reg, init_cnt_next;
  logic [CTR_W-1:0]   ctr_reg, ctr_next;
  logic [WORD_W-1:0]  word_reg, word_next;

  logic halt_any;
  logic at_eow;
  logic halted;

  assign halt_any = |i_sync_halt_req;
  assign at_eow   = (ctr_reg == CTR_LAST);
  assign halted   = (state_reg == SYNC_HALT);

  always_ff @(posedge i_sync_gck or posedge i_sync_rst) begin
    if (i_sync_rst) begin
      state_reg    <= SYNC_INIT;
      init_cnt_reg <= '0;
      ctr_reg      <= '0;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      ctr_reg      <= ctr_next;
      word_reg     <= word_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    ctr_next      = ctr_reg;
    word_next     = word_reg;

    case (state_reg)
      SYNC_INIT: begin
        ctr_next = '0;
        // INIT_LAST is 0 for INIT_CYC of 0 or 1, so both leave on the first edge.
        if (init_cnt_reg == INIT_LAST) begin
          state_next    = SYNC_RUN;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt_reg + 1'b1;
        end
      end

      SYNC_RUN: begin
        ctr_next = ctr_reg + 1'b1;
        if (at_eow) begin
          word_next = word_reg + 1'b1;
          // Requests are only sampled on the last slice; earlier pulses are lost.
          if (halt_any) begin
            state_next = SYNC_HALT;
            ctr_next   = '0;
          end
        end
      end

      SYNC_HALT: begin
        ctr_next = '0;
        if (!halt_any) begin
          state_next = SYNC_RUN;
        end
      end

      default: begin
        state_next    = SYNC_INIT;
        init_cnt_next = '0;
        ctr_next      = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ack
      assign o_sync_halt_ack[gi] = halted & i_sync_halt_req[gi];
    end
  endgenerate

  assign o_sync_run  = (state_reg == SYNC_RUN);
  assign o_sync_sow  = o_sync_run && (ctr_reg == '0);
  assign o_sync_eow  = o_sync_run && at_eow;
  assign o_sync_ctr  = ctr_reg;
  assign o_sync_word = word_reg;

endmodule
